hs_req_initiator: RTL and testbench

HS_REQ_INITIATOR -- requirements
Module: hs_req_initiator

---
 rtl/hs_req_initiator.sv | 115 +++++++++++
 tb/tb_hs_req_initiator.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hs_req_initiator.sv
// Four-phase request initiator: accepts one payload from a valid/ready
// upstream, holds it on data_out and runs a req/ack handshake toward a
// remote domain, with an optional watchdog on the ack rise.
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - upstream offer / accept (in_ready is combinational)
//   in_data             - upstream payload
//   req_out, data_out   - registered request and held payload
//   ack_in              - remote acknowledge, already synchronized to clk
//   done                - one-cycle pulse on normal handshake completion
//   timeout_err         - sticky flag, set when ack never rose in time
//   err_clr             - clears timeout_err (a coincident timeout wins)
//   busy                - high whenever the FSM is not IDLE
module hs_req_initiator #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              req_out,
   output logic [DATA_W-1:0] data_out,
   input  logic              ack_in,
   output logic              done,
   output logic              timeout_err,
   input  logic              err_clr,
   output logic              busy
);

   localparam int unsigned CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam bit          TO_EN  = (TIMEOUT_CYC != 0);
   // Last counter value before the watchdog fires; the counter saturates at CNT_MAX.
   localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYC > 1) ? CNT_W'(TIMEOUT_CYC - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WAIT_ACK_HI = 2'd1,
      WAIT_ACK_LO = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             timed_out;
   logic             accept;
   logic             timeout_hit;

   // A lingering ack from a previous handshake must drop before a new request.
   assign in_ready = (state == IDLE) && !ack_in;
   assign accept   = in_valid && in_ready;
   assign busy     = (state != IDLE);

   // Watchdog fires only if ack is still low; a coincident ack rise wins.
   assign timeout_hit = TO_EN && (state == WAIT_ACK_HI) && !ack_in && (cnt == TO_LAST);

   // Handshake FSM with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         req_out     <= 1'b0;
         data_out    <= '0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
         cnt         <= '0;
         timed_out   <= 1'b0;
      end else begin
         done <= 1'b0;

         // Sticky error: set beats clear.
         if (timeout_hit) begin
            timeout_err <= 1'b1;
         end else if (err_clr) begin
            timeout_err <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (accept) begin
                  data_out  <= in_data;
                  req_out   <= 1'b1;
                  cnt       <= '0;
                  timed_out <= 1'b0;
                  state     <= WAIT_ACK_HI;
               end
            end
            WAIT_ACK_HI: begin
               if (ack_in) begin
                  req_out <= 1'b0;
                  state   <= WAIT_ACK_LO;
               end else if (timeout_hit) begin
                  req_out   <= 1'b0;
                  timed_out <= 1'b1;
                  state     <= WAIT_ACK_LO;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            WAIT_ACK_LO: begin
               // An aborted transfer returns to IDLE silently.
               if (!ack_in) begin
                  done  <= !timed_out;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hs_req_initiator.sv
// Directed bench for hs_req_initiator (DATA_W=32, TIMEOUT_CYC=8): a table
// of per-cycle vectors plus hand sequences for back-to-back and reset.
module tb_hs_req_initiator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        req_out;
   logic [31:0] data_out;
   logic        ack_in;
   logic        done;
   logic        timeout_err;
   logic        err_clr;
   logic        busy;

   hs_req_initiator #(.DATA_W(32), .TIMEOUT_CYC(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .req_out     (req_out),
      .data_out    (data_out),
      .ack_in      (ack_in),
      .done        (done),
      .timeout_err (timeout_err),
      .err_clr     (err_clr),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [31:0] d;
      logic        ack;
      logic        clr;
      logic        e_rdy;
      logic        e_req;
      logic [31:0] e_data;
      logic        e_done;
      logic        e_te;
      logic        e_busy;
   } vec_t;

   vec_t tbl[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cur   = -1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (vec %0d): got %h, expected %h", nm, cur, act, exp);
      end
   endtask

   function automatic vec_t mk(logic iv, logic [31:0] d, logic ack, logic clr,
                               logic rdy, logic req, logic [31:0] dat,
                               logic dn, logic te, logic bz);
      vec_t v;
      v.iv = iv; v.d = d; v.ack = ack; v.clr = clr;
      v.e_rdy = rdy; v.e_req = req; v.e_data = dat;
      v.e_done = dn; v.e_te = te; v.e_busy = bz;
      return v;
   endfunction

   initial begin
      int acc_n, done_n, both_n, cyc;
      logic seen;

      // Single transfer: ack 4 cycles after req rise, drops 3 cycles after req fall.
      tbl.push_back(mk(0, 0, 0, 0,  1, 0, 32'h0, 0, 0, 0));
      tbl.push_back(mk(1, 32'hA5A5_0001, 0, 0,  1, 1, 32'hA5A5_0001, 0, 0, 1));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 0,  0, 1, 32'hA5A5_0001, 0, 0, 1));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 1, 0,  0, 0, 32'hA5A5_0001, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0,  0, 0, 32'hA5A5_0001, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0,  1, 0, 32'hA5A5_0001, 0, 0, 0));
      // Stuck ack while IDLE: nothing accepted until it drops.
      tbl.push_back(mk(1, 32'h11, 1, 0,  0, 0, 32'hA5A5_0001, 0, 0, 0));
      tbl.push_back(mk(1, 32'h22, 1, 0,  0, 0, 32'hA5A5_0001, 0, 0, 0));
      tbl.push_back(mk(1, 32'h33, 0, 0,  1, 1, 32'h33, 0, 0, 1));
      tbl.push_back(mk(0, 0, 1, 0,  0, 0, 32'h33, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0,  0, 0, 32'h33, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0,  1, 0, 32'h33, 0, 0, 0));
      // Race: ack rises on the 8th WAIT_ACK_HI cycle (the timeout cycle).
      tbl.push_back(mk(1, 32'h44, 0, 0,  1, 1, 32'h44, 0, 0, 1));
      for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 0, 0, 0,  0, 1, 32'h44, 0, 0, 1));
      tbl.push_back(mk(0, 0, 1, 0,  0, 0, 32'h44, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0,  0, 0, 32'h44, 1, 0, 0));
      // Timeout: req held 8 cycles, error set, no done.
      tbl.push_back(mk(1, 32'h55, 0, 0,  1, 1, 32'h55, 0, 0, 1));
      for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 0, 0, 0,  0, 1, 32'h55, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0,  0, 0, 32'h55, 0, 1, 1));
      tbl.push_back(mk(0, 0, 0, 0,  0, 0, 32'h55, 0, 1, 0));
      // Error flag does not block; timeout coincident with err_clr keeps the flag.
      tbl.push_back(mk(1, 32'h66, 0, 0,  1, 1, 32'h66, 0, 1, 1));
      for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 0, 0, 0,  0, 1, 32'h66, 0, 1, 1));
      tbl.push_back(mk(0, 0, 0, 1,  0, 0, 32'h66, 0, 1, 1));
      tbl.push_back(mk(0, 0, 0, 0,  0, 0, 32'h66, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 1,  1, 0, 32'h66, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0,  1, 0, 32'h66, 0, 0, 0));

      // Reset
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; ack_in = 1'b0; err_clr = 1'b0;
      #12;
      chk("rst_req", 32'(req_out), 32'h0);
      chk("rst_data", data_out, 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_te", 32'(timeout_err), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table vectors: inputs at negedge, in_ready checked before the edge,
      // registered outputs checked just after it.
      foreach (tbl[i]) begin
         cur      = i;
         in_valid = tbl[i].iv;
         in_data  = tbl[i].d;
         ack_in   = tbl[i].ack;
         err_clr  = tbl[i].clr;
         #1;
         chk("in_ready", 32'(in_ready), 32'(tbl[i].e_rdy));
         @(posedge clk); #1;
         chk("req_out", 32'(req_out), 32'(tbl[i].e_req));
         chk("data_out", data_out, tbl[i].e_data);
         chk("done", 32'(done), 32'(tbl[i].e_done));
         chk("timeout_err", 32'(timeout_err), 32'(tbl[i].e_te));
         chk("busy", 32'(busy), 32'(tbl[i].e_busy));
         @(negedge clk);
      end
      cur = -1;
      in_valid = 1'b0; err_clr = 1'b0; ack_in = 1'b0;

      // Back-to-back: 16 payloads, ack mirrors req_out.
      acc_n = 0; done_n = 0; both_n = 0; cyc = 0;
      while (done_n < 16 && cyc < 300) begin
         ack_in   = req_out;
         in_valid = (acc_n < 16);
         in_data  = 32'(acc_n);
         #1;
         if (in_valid && in_ready) acc_n++;
         @(posedge clk); #1;
         if (done) begin
            chk("b2b_data", data_out, 32'(done_n));
            if (in_ready && in_valid) both_n++;
            done_n++;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0; ack_in = 1'b0;
      chk("b2b_done_cnt", 32'(done_n), 32'd16);
      chk("b2b_accepts", 32'(acc_n), 32'd16);
      chk("b2b_overlap", 32'(both_n), 32'd15);

      // Reset mid-handshake.
      in_valid = 1'b1; in_data = 32'h77;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("mid_req_pre", 32'(req_out), 32'h1);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("mid_req", 32'(req_out), 32'h0);
      chk("mid_busy", 32'(busy), 32'h0);
      chk("mid_data", data_out, 32'h0);
      @(negedge clk);
      ack_in = 1'b1; rst_n = 1'b1; in_valid = 1'b1; in_data = 32'h88;
      #1;
      chk("post_rst_rdy_ack", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      chk("post_rst_busy", 32'(busy), 32'h0);
      @(negedge clk);
      ack_in = 1'b0;
      #1;
      chk("post_rst_rdy", 32'(in_ready), 32'h1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("post_rst_req", 32'(req_out), 32'h1);
      chk("post_rst_data", data_out, 32'h88);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         ack_in = req_out;
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      chk("post_rst_done", 32'(seen), 32'h1);
      chk("post_rst_te", 32'(timeout_err), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
